// File: rtl/bmem_resp.sv
// Line-bus responder: fixed-latency line reads, posted zero-wait line writes.
// Optional BMEM_RANGE_CHECK_EN adds b_err and drops out-of-range writes.
module bmem_resp #(
  parameter int LINE_W     = 1024,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [63:0]       b_addr,
  input  logic              b_rd,
  output logic [LINE_W-1:0] b_rdata,
  output logic              b_dv,
  input  logic              b_wr,
  input  logic [LINE_W-1:0] b_wdata,
  output logic              b_busy
`ifdef BMEM_RANGE_CHECK_EN
  ,
  output logic              b_err
`endif
);

  localparam int IDX_LO = 7;
  localparam int IDX_HI = IDX_LO + DEPTH_LOG2 - 1;
  localparam int NLINES = 2 ** DEPTH_LOG2;
  localparam logic [7:0] CNT_INIT =
    (RD_LAT >= 2) ? 8'(RD_LAT - 2) : 8'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   ridx_q, ridx_d;
  logic                    roor_q, roor_d;
  logic [LINE_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [LINE_W-1:0]       mem_q [NLINES];

  logic [DEPTH_LOG2-1:0]   a_idx;
  logic                    a_oor;
  logic                    wr_en;
  logic                    load;
  logic [DEPTH_LOG2-1:0]   lidx;
  logic                    loor;
  logic                    unused_ok;

  assign a_idx = b_addr[IDX_HI:IDX_LO];

`ifdef BMEM_RANGE_CHECK_EN
  assign a_oor     = |b_addr[63:IDX_HI+1];
  assign b_err     = err_q;
  assign unused_ok = ^b_addr[IDX_LO-1:0];
`else
  // Upper address bits alias onto the line index.
  assign a_oor     = 1'b0;
  assign unused_ok = ^{b_addr[IDX_LO-1:0],
                       b_addr[63:IDX_HI+1], err_q};
`endif

  assign wr_en   = b_wr & ~a_oor;
  assign b_dv    = (state_q == RESP);
  assign b_busy  = (state_q != IDLE);
  assign b_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ridx_d  = ridx_q;
    roor_d  = roor_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    load    = 1'b0;
    lidx    = ridx_q;
    loor    = roor_q;
    unique case (state_q)
      IDLE: begin
        if (b_rd) begin
          ridx_d = a_idx;
          roor_d = a_oor;
          if (RD_LAT == 1) begin
            state_d = RESP;
            load    = 1'b1;
            lidx    = a_idx;
            loor    = a_oor;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!b_rd) begin
          state_d = IDLE;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = RESP;
          load    = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A write landing on the load edge must win over stale RAM.
    if (load) begin
      err_d = loor;
      if (loor) begin
        rdata_d = '0;
      end else if (wr_en && (a_idx == lidx)) begin
        rdata_d = b_wdata;
      end else begin
        rdata_d = mem_q[lidx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ridx_q  <= '0;
      roor_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ridx_q  <= ridx_d;
      roor_q  <= roor_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[a_idx] <= b_wdata;
    end
  end

endmodule

// File: tb/tb_bmem_resp.sv
// Directed bench for bmem_resp: RD_LAT=4 and RD_LAT=1 instances.
// Range-check scenario built only with BMEM_RANGE_CHECK_EN.
module tb_bmem_resp;

  localparam int LINE_W = 1024;
  localparam logic [LINE_W-1:0] P_A5 = {16{64'h0000_0000_0000_A5A5}};
  localparam logic [LINE_W-1:0] P_1S = {LINE_W{1'b1}};
  localparam logic [LINE_W-1:0] P_11 = {32{32'h1111_2222}};
  localparam logic [LINE_W-1:0] P_DE = {32{32'hDEAD_BEEF}};
  localparam logic [LINE_W-1:0] P_BE = {32{32'hBEEF_0001}};
  localparam logic [LINE_W-1:0] P_L1 = {32{32'h0101_0101}};
  localparam logic [LINE_W-1:0] P_L2 = {32{32'h0202_0202}};
  localparam logic [LINE_W-1:0] P_77 = {32{32'h7777_0007}};
  localparam logic [LINE_W-1:0] P_88 = {32{32'h8888_0008}};
  localparam logic [LINE_W-1:0] P_99 = {32{32'h9999_0009}};

  logic              clk = 1'b0;
  logic              clr_n;
  logic [63:0]       b_addr;
  logic              b_wr;
  logic [LINE_W-1:0] b_wdata;
  logic              rd4, rd1;
  logic [LINE_W-1:0] rdata4, rdata1;
  logic              dv4, dv1, busy4, busy1;
  logic              err4;
`ifdef BMEM_RANGE_CHECK_EN
  logic              err1;
`else
  assign err4 = 1'b0;
`endif

  int cmp  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  bmem_resp #(.LINE_W(LINE_W), .DEPTH_LOG2(10), .RD_LAT(4)) dut4 (
    .clk(clk), .clr_n(clr_n), .b_addr(b_addr), .b_rd(rd4),
    .b_rdata(rdata4), .b_dv(dv4), .b_wr(b_wr),
    .b_wdata(b_wdata), .b_busy(busy4)
`ifdef BMEM_RANGE_CHECK_EN
    , .b_err(err4)
`endif
  );

  bmem_resp #(.LINE_W(LINE_W), .DEPTH_LOG2(10), .RD_LAT(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .b_addr(b_addr), .b_rd(rd1),
    .b_rdata(rdata1), .b_dv(dv1), .b_wr(b_wr),
    .b_wdata(b_wdata), .b_busy(busy1)
`ifdef BMEM_RANGE_CHECK_EN
    , .b_err(err1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_line(input logic [63:0] a,
                         input logic [LINE_W-1:0] d);
    b_addr  = a;
    b_wdata = d;
    b_wr    = 1'b1;
    tick();
    b_wr    = 1'b0;
  endtask

  // Drives a read on the RD_LAT=4 instance; cyc is the edge index of b_dv.
  task automatic do_read4(input logic [63:0] a,
                          output logic [LINE_W-1:0] d,
                          output logic e, output int cyc,
                          output int n, output logic busy0);
    d = '0; e = 1'b0; cyc = -1; n = 0; busy0 = 1'b0;
    b_addr = a;
    rd4 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) busy0 = busy4;
      if (dv4) begin
        n++;
        if (cyc < 0) begin
          cyc = k; d = rdata4; e = err4;
        end
        rd4 = 1'b0;
      end
    end
    rd4 = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    tick();
    tick();
    cmp++; if (dv4 !== 1'b0) begin errs++; $display("FAIL rst_dv4: got %b want 0", dv4); end
    cmp++; if (busy4 !== 1'b0) begin errs++; $display("FAIL rst_busy4: got %b want 0", busy4); end
    cmp++; if (rdata4 !== '0) begin errs++; $display("FAIL rst_rdata4: got %h want 0", rdata4[63:0]); end
    cmp++; if (dv1 !== 1'b0) begin errs++; $display("FAIL rst_dv1: got %b want 0", dv1); end
    cmp++; if (busy1 !== 1'b0) begin errs++; $display("FAIL rst_busy1: got %b want 0", busy1); end
`ifdef BMEM_RANGE_CHECK_EN
    cmp++; if (err4 !== 1'b0 || err1 !== 1'b0) begin errs++; $display("FAIL rst_err: got %b%b want 00", err4, err1); end
`endif
    clr_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    logic [LINE_W-1:0] d;
    logic e, b0;
    int cyc, n;
    wr_line(64'h280, P_A5);
    do_read4(64'h280, d, e, cyc, n, b0);
    cmp++; if (b0 !== 1'b1) begin errs++; $display("FAIL t1_busy: got %b want 1", b0); end
    cmp++; if (cyc !== 3) begin errs++; $display("FAIL t1_dv_cycle: got %0d want 3", cyc); end
    cmp++; if (n !== 1) begin errs++; $display("FAIL t1_dv_count: got %0d want 1", n); end
    cmp++; if (d !== P_A5) begin errs++; $display("FAIL t1_data: got %h want %h", d[63:0], P_A5[63:0]); end
    cmp++; if (rdata4 !== P_A5) begin errs++; $display("FAIL t1_hold: got %h want %h", rdata4[63:0], P_A5[63:0]); end
  endtask

  task automatic test_offset();
    logic [LINE_W-1:0] d;
    logic e, b0;
    int cyc, n;
    wr_line(64'h300, P_1S);
    do_read4(64'h37F, d, e, cyc, n, b0);
    cmp++; if (d !== P_1S) begin errs++; $display("FAIL t2_data: got %h want %h", d[63:0], P_1S[63:0]); end
    cmp++; if (cyc !== 3) begin errs++; $display("FAIL t2_dv_cycle: got %0d want 3", cyc); end
  endtask

  task automatic test_forward();
    logic [LINE_W-1:0] d;
    logic e, b0;
    int cyc, n;
    wr_line(64'h180, P_11);
    b_addr = 64'h180;
    rd4 = 1'b1;
    tick();
    b_wr = 1'b1;
    b_wdata = P_DE;
    tick();
    b_wr = 1'b0;
    b_addr = 64'h280;
    cyc = -1;
    d = '0;
    for (int k = 2; k < 12; k++) begin
      tick();
      if (dv4 && cyc < 0) begin
        cyc = k; d = rdata4; rd4 = 1'b0;
      end
    end
    rd4 = 1'b0;
    cmp++; if (d !== P_DE) begin errs++; $display("FAIL t3_wait_fwd: got %h want %h", d[63:0], P_DE[63:0]); end
    cmp++; if (cyc !== 3) begin errs++; $display("FAIL t3_wait_cycle: got %0d want 3", cyc); end
    // Write on the very edge that loads the response.
    b_addr = 64'h180;
    rd4 = 1'b1;
    tick();
    tick();
    tick();
    b_wr = 1'b1;
    b_wdata = P_BE;
    tick();
    b_wr = 1'b0;
    cmp++; if (dv4 !== 1'b1) begin errs++; $display("FAIL t3_resp_dv: got %b want 1", dv4); end
    cmp++; if (rdata4 !== P_BE) begin errs++; $display("FAIL t3_resp_fwd: got %h want %h", rdata4[63:0], P_BE[63:0]); end
    rd4 = 1'b0;
    tick();
    cmp++; if (dv4 !== 1'b0) begin errs++; $display("FAIL t3_dv_pulse: got %b want 0", dv4); end
    do_read4(64'h180, d, e, cyc, n, b0);
    cmp++; if (d !== P_BE) begin errs++; $display("FAIL t3_committed: got %h want %h", d[63:0], P_BE[63:0]); end
  endtask

  task automatic test_abort();
    logic [LINE_W-1:0] d;
    logic e, b0;
    int cyc, n;
    b_addr = 64'h280;
    rd4 = 1'b1;
    tick();
    cmp++; if (busy4 !== 1'b1) begin errs++; $display("FAIL t4_busy_wait: got %b want 1", busy4); end
    tick();
    rd4 = 1'b0;
    tick();
    cmp++; if (busy4 !== 1'b0) begin errs++; $display("FAIL t4_busy_abort: got %b want 0", busy4); end
    n = 0;
    repeat (6) begin
      tick();
      if (dv4) n++;
    end
    cmp++; if (n !== 0) begin errs++; $display("FAIL t4_abort_dv: got %0d want 0", n); end
    rd4 = 1'b1;
    tick();
    tick();
    clr_n = 1'b0;
    rd4 = 1'b0;
    tick();
    cmp++; if (busy4 !== 1'b0) begin errs++; $display("FAIL t4_rst_busy: got %b want 0", busy4); end
    cmp++; if (dv4 !== 1'b0) begin errs++; $display("FAIL t4_rst_dv: got %b want 0", dv4); end
    cmp++; if (rdata4 !== '0) begin errs++; $display("FAIL t4_rst_rdata: got %h want 0", rdata4[63:0]); end
    clr_n = 1'b1;
    n = 0;
    repeat (5) begin
      tick();
      if (dv4) n++;
    end
    cmp++; if (n !== 0) begin errs++; $display("FAIL t4_rst_nodv: got %0d want 0", n); end
    do_read4(64'h280, d, e, cyc, n, b0);
    cmp++; if (d !== P_A5) begin errs++; $display("FAIL t4_ram_kept: got %h want %h", d[63:0], P_A5[63:0]); end
  endtask

  task automatic test_back_to_back();
    wr_line(64'h080, P_L1);
    wr_line(64'h100, P_L2);
    b_addr = 64'h080;
    rd1 = 1'b1;
    tick();
    cmp++; if (dv1 !== 1'b1) begin errs++; $display("FAIL t5_dv_c1: got %b want 1", dv1); end
    cmp++; if (rdata1 !== P_L1) begin errs++; $display("FAIL t5_data1: got %h want %h", rdata1[63:0], P_L1[63:0]); end
    b_addr = 64'h100;
    tick();
    cmp++; if (dv1 !== 1'b0) begin errs++; $display("FAIL t5_dv_c2: got %b want 0", dv1); end
    tick();
    cmp++; if (dv1 !== 1'b1) begin errs++; $display("FAIL t5_dv_c3: got %b want 1", dv1); end
    cmp++; if (rdata1 !== P_L2) begin errs++; $display("FAIL t5_data2: got %h want %h", rdata1[63:0], P_L2[63:0]); end
    rd1 = 1'b0;
    tick();
    cmp++; if (dv1 !== 1'b0 || rdata1 !== P_L2) begin errs++; $display("FAIL t5_after: got dv %b data %h want dv 0 data %h", dv1, rdata1[63:0], P_L2[63:0]); end
  endtask

  task automatic test_rd_wr_same();
    logic [LINE_W-1:0] d;
    int cyc;
    b_addr = 64'h380;
    b_wdata = P_77;
    b_wr = 1'b1;
    rd4 = 1'b1;
    tick();
    b_wr = 1'b0;
    cyc = -1;
    d = '0;
    for (int k = 1; k < 12; k++) begin
      tick();
      if (dv4 && cyc < 0) begin
        cyc = k; d = rdata4; rd4 = 1'b0;
      end
    end
    rd4 = 1'b0;
    cmp++; if (d !== P_77 || cyc !== 3) begin errs++; $display("FAIL rdwr_lat4: got %h at %0d want %h at 3", d[63:0], cyc, P_77[63:0]); end
    b_addr = 64'h400;
    b_wdata = P_88;
    b_wr = 1'b1;
    rd1 = 1'b1;
    tick();
    b_wr = 1'b0;
    rd1 = 1'b0;
    cmp++; if (dv1 !== 1'b1 || rdata1 !== P_88) begin errs++; $display("FAIL rdwr_lat1: got dv %b data %h want dv 1 data %h", dv1, rdata1[63:0], P_88[63:0]); end
    tick();
  endtask

`ifdef BMEM_RANGE_CHECK_EN
  task automatic test_range();
    logic [LINE_W-1:0] d;
    logic e, b0;
    int cyc, n;
    do_read4(64'h2_0000, d, e, cyc, n, b0);
    cmp++; if (cyc !== 3) begin errs++; $display("FAIL t6_dv_cycle: got %0d want 3", cyc); end
    cmp++; if (e !== 1'b1) begin errs++; $display("FAIL t6_err: got %b want 1", e); end
    cmp++; if (d !== '0) begin errs++; $display("FAIL t6_data: got %h want 0", d[63:0]); end
    cmp++; if (err4 !== 1'b0) begin errs++; $display("FAIL t6_err_pulse: got %b want 0", err4); end
    wr_line(64'h2_0280, P_99);
    do_read4(64'h280, d, e, cyc, n, b0);
    cmp++; if (d !== P_A5) begin errs++; $display("FAIL t6_wr_dropped: got %h want %h", d[63:0], P_A5[63:0]); end
    cmp++; if (e !== 1'b0) begin errs++; $display("FAIL t6_err_inrange: got %b want 0", e); end
  endtask
`else
  task automatic test_alias();
    logic [LINE_W-1:0] d;
    logic e, b0;
    int cyc, n;
    wr_line(64'h0000_0100_0000_0480, P_99);
    do_read4(64'h480, d, e, cyc, n, b0);
    cmp++; if (d !== P_99) begin errs++; $display("FAIL alias_data: got %h want %h", d[63:0], P_99[63:0]); end
  endtask
`endif

  initial begin
    clr_n = 1'b0;
    b_addr = '0;
    b_wr = 1'b0;
    b_wdata = '0;
    rd4 = 1'b0;
    rd1 = 1'b0;
    tick();
    test_reset();
    test_latency();
    test_offset();
    test_forward();
    test_abort();
    test_back_to_back();
    test_rd_wr_same();
`ifdef BMEM_RANGE_CHECK_EN
    test_range();
`else
    test_alias();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
